// File: rtl/matmul_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_loader_if
// Purpose  : Element stream plus M1/M2 RAM write ports of the matrix loader.
// Revision : 1.0
// ============================================================================
interface matmul_loader_if #(
    parameter int A    = 16,
    parameter int B    = 32,
    parameter int C    = 24,
    parameter int BITS = 8
);
    localparam int M12_W = B * BITS;
    localparam int AW    = (A > 1) ? $clog2(A) : 1;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;

    logic [BITS-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    m1_wr_addr;
    logic [M12_W-1:0] m1_wr_data;
    logic             m1_wr_ena;
    logic [CW-1:0]    m2_wr_addr;
    logic [M12_W-1:0] m2_wr_data;
    logic             m2_wr_ena;
    logic             load_done;

    // Upstream producer / RAM side.
    modport master (
        output in_data, in_valid,
        input  in_ready, m1_wr_addr, m1_wr_data, m1_wr_ena,
        input  m2_wr_addr, m2_wr_data, m2_wr_ena, load_done
    );

    // Loader side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, m1_wr_addr, m1_wr_data, m1_wr_ena,
        output m2_wr_addr, m2_wr_data, m2_wr_ena, load_done
    );
endinterface
`default_nettype wire

// File: rtl/matmul_loader.sv
`default_nettype none
// ============================================================================
// Module   : matmul_loader
// Purpose  : Packs an element stream into row words, fills M1 then M2 RAM.
// Revision : 1.0
// ============================================================================
module matmul_loader #(
    parameter int A    = 16,
    parameter int B    = 32,
    parameter int C    = 24,
    parameter int BITS = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    matmul_loader_if.slave bus
);
    localparam int M12_W = B * BITS;
    localparam int AW    = (A > 1) ? $clog2(A) : 1;
    localparam int CW    = (C > 1) ? $clog2(C) : 1;
    localparam int RW    = (AW > CW) ? AW : CW;
    localparam int EW    = (B > 1) ? $clog2(B) : 1;
    localparam int BUF_W = M12_W - BITS;

    typedef enum logic [1:0] {
        LOAD_M1 = 2'd0,
        LOAD_M2 = 2'd1,
        FLUSH   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    elem_q, elem_d;
    logic [RW-1:0]    row_q, row_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [AW-1:0]    m1_addr_q, m1_addr_d;
    logic [M12_W-1:0] m1_data_q, m1_data_d;
    logic             m1_ena_q, m1_ena_d;
    logic [CW-1:0]    m2_addr_q, m2_addr_d;
    logic [M12_W-1:0] m2_data_q, m2_data_d;
    logic             m2_ena_q, m2_ena_d;
    logic             done_q, done_d;

    logic ready;
    logic accept;
    logic last_elem;

    assign ready     = ((state_q == LOAD_M1) || (state_q == LOAD_M2)) && !clear;
    assign accept    = bus.in_valid && ready;
    assign last_elem = (elem_q == EW'(B - 1));

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        row_d     = row_q;
        buf_d     = buf_q;
        m1_addr_d = m1_addr_q;
        m1_data_d = m1_data_q;
        m1_ena_d  = 1'b0;
        m2_addr_d = m2_addr_q;
        m2_data_d = m2_data_q;
        m2_ena_d  = 1'b0;
        done_d    = done_q;

        if (clear) begin
            state_d = LOAD_M1;
            elem_d  = '0;
            row_d   = '0;
            done_d  = 1'b0;
        end else begin
            // Partial elements go to the assembly buffer; the final element of a
            // row bypasses it so the next row can start filling immediately.
            if (accept && !last_elem) begin
                buf_d[int'(elem_q) * BITS +: BITS] = bus.in_data;
                elem_d = elem_q + EW'(1);
            end
            case (state_q)
                LOAD_M1: begin
                    if (accept && last_elem) begin
                        elem_d    = '0;
                        m1_addr_d = row_q[AW-1:0];
                        m1_data_d = {bus.in_data, buf_q};
                        m1_ena_d  = 1'b1;
                        if (row_q == RW'(A - 1)) begin
                            row_d   = '0;
                            state_d = LOAD_M2;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                LOAD_M2: begin
                    if (accept && last_elem) begin
                        elem_d    = '0;
                        m2_addr_d = row_q[CW-1:0];
                        m2_data_d = {bus.in_data, buf_q};
                        m2_ena_d  = 1'b1;
                        if (row_q == RW'(C - 1)) begin
                            row_d   = '0;
                            state_d = FLUSH;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end
                end
                FLUSH: begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = DONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD_M1;
            elem_q    <= '0;
            row_q     <= '0;
            buf_q     <= '0;
            m1_addr_q <= '0;
            m1_data_q <= '0;
            m1_ena_q  <= 1'b0;
            m2_addr_q <= '0;
            m2_data_q <= '0;
            m2_ena_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            elem_q    <= elem_d;
            row_q     <= row_d;
            buf_q     <= buf_d;
            m1_addr_q <= m1_addr_d;
            m1_data_q <= m1_data_d;
            m1_ena_q  <= m1_ena_d;
            m2_addr_q <= m2_addr_d;
            m2_data_q <= m2_data_d;
            m2_ena_q  <= m2_ena_d;
            done_q    <= done_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.m1_wr_addr = m1_addr_q;
    assign bus.m1_wr_data = m1_data_q;
    assign bus.m1_wr_ena  = m1_ena_q;
    assign bus.m2_wr_addr = m2_addr_q;
    assign bus.m2_wr_data = m2_data_q;
    assign bus.m2_wr_ena  = m2_ena_q;
    assign bus.load_done  = done_q;
endmodule
`default_nettype wire

// File: tb/tb_matmul_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_loader
// Purpose  : Randomized stimulus against a stream-level model of the loader.
// Revision : 1.0
// ============================================================================
module tb_matmul_loader;
    localparam int SA    = 2;
    localparam int SB    = 4;
    localparam int SC    = 3;
    localparam int TOTAL = (SA + SC) * SB;
    localparam int BIG_N = (16 + 24) * 32;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    always #5 clk = ~clk;

    matmul_loader_if #(.A(SA), .B(SB), .C(SC), .BITS(8)) s_if ();
    matmul_loader_if #(.A(16), .B(32), .C(24), .BITS(8)) b_if ();

    matmul_loader #(.A(SA), .B(SB), .C(SC), .BITS(8)) u_small (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(clear),
        .bus  (s_if)
    );

    matmul_loader u_big (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(1'b0),
        .bus  (b_if)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // Stream-level model: element count within the load, current row bytes,
    // the write expected this cycle, and cycles elapsed since the final accept.
    int          m_n;
    logic [7:0]  m_row [SB];
    logic        m_e1, m_e2;
    int          m_addr;
    logic [31:0] m_data;
    int          m_since;
    int          pulses = 0;
    logic [31:0] ram1 [SA];
    logic [31:0] ram2 [SC];

    logic [255:0] bram1 [16];
    logic [255:0] bram2 [24];
    logic [7:0]   gold  [BIG_N];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit exp_ready;
        bit acc;
        int r;
        forever begin
            @(negedge clk);
            if (b_if.m1_wr_ena) bram1[b_if.m1_wr_addr] = b_if.m1_wr_data;
            if (b_if.m2_wr_ena) bram2[b_if.m2_wr_addr] = b_if.m2_wr_data;
            if (!rst_n) begin
                chk("rst_in_ready", 256'(s_if.in_ready), 256'(1));
                chk("rst_m1_ena", 256'(s_if.m1_wr_ena), 256'(0));
                chk("rst_m2_ena", 256'(s_if.m2_wr_ena), 256'(0));
                chk("rst_m1_addr", 256'(s_if.m1_wr_addr), 256'(0));
                chk("rst_m1_data", 256'(s_if.m1_wr_data), 256'(0));
                chk("rst_m2_addr", 256'(s_if.m2_wr_addr), 256'(0));
                chk("rst_m2_data", 256'(s_if.m2_wr_data), 256'(0));
                chk("rst_load_done", 256'(s_if.load_done), 256'(0));
                m_n = 0; m_e1 = 0; m_e2 = 0; m_since = -1;
            end else begin
                exp_ready = (m_n < TOTAL) && !clear;
                chk("in_ready", 256'(s_if.in_ready), 256'(exp_ready));
                chk("m1_wr_ena", 256'(s_if.m1_wr_ena), 256'(m_e1));
                chk("m2_wr_ena", 256'(s_if.m2_wr_ena), 256'(m_e2));
                if (m_e1) begin
                    chk("m1_wr_addr", 256'(s_if.m1_wr_addr), 256'(m_addr));
                    chk("m1_wr_data", 256'(s_if.m1_wr_data), 256'(m_data));
                end
                if (m_e2) begin
                    chk("m2_wr_addr", 256'(s_if.m2_wr_addr), 256'(m_addr));
                    chk("m2_wr_data", 256'(s_if.m2_wr_data), 256'(m_data));
                end
                chk("load_done", 256'(s_if.load_done), 256'(m_since >= 2));
                if (s_if.m1_wr_ena) begin ram1[s_if.m1_wr_addr] = s_if.m1_wr_data; pulses++; end
                if (s_if.m2_wr_ena) begin
                    if (int'(s_if.m2_wr_addr) < SC) ram2[s_if.m2_wr_addr] = s_if.m2_wr_data;
                    pulses++;
                end
                acc  = s_if.in_valid && exp_ready;
                m_e1 = 0;
                m_e2 = 0;
                if (clear) begin
                    m_n = 0;
                    m_since = -1;
                end else if (acc) begin
                    m_row[m_n % SB] = s_if.in_data;
                    m_n++;
                    if (m_n % SB == 0) begin
                        r = m_n / SB - 1;
                        for (int k = 0; k < SB; k++) m_data[k*8 +: 8] = m_row[k];
                        if (r < SA) begin m_e1 = 1; m_addr = r; end
                        else begin m_e2 = 1; m_addr = r - SA; end
                        if (m_n == TOTAL) m_since = 1;
                    end
                end else if (m_since > 0 && m_since < 1000) begin
                    m_since++;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic s_send(input logic [7:0] d, input int gap);
        bit r;
        int tries;
        if (gap > 0 && int'($urandom_range(99)) < gap) begin
            s_if.in_valid = 1'b0;
            s_if.in_data  = 8'($urandom);
            step();
        end
        s_if.in_valid = 1'b1;
        s_if.in_data  = d;
        tries = 0;
        forever begin
            @(negedge clk);
            r = s_if.in_ready;
            step();
            if (r) break;
            tries++;
            if (tries > 50) begin
                n_checks++; n_errs++;
                $display("FAIL small_accept_timeout: got no accept expected accept of %0h", d);
                break;
            end
        end
    endtask

    task automatic s_stream(input logic [7:0] base, input int cnt, input int gap);
        for (int i = 0; i < cnt; i++) s_send(base + 8'(i), gap);
        s_if.in_valid = 1'b0;
    endtask

    task automatic b_send(input logic [7:0] d, input int gap);
        bit r;
        int tries;
        if (gap > 0 && int'($urandom_range(99)) < gap) begin
            b_if.in_valid = 1'b0;
            step();
        end
        b_if.in_valid = 1'b1;
        b_if.in_data  = d;
        tries = 0;
        forever begin
            @(negedge clk);
            r = b_if.in_ready;
            step();
            if (r) break;
            tries++;
            if (tries > 50) begin
                n_checks++; n_errs++;
                $display("FAIL big_accept_timeout: got no accept expected accept of %0h", d);
                break;
            end
        end
    endtask

    task automatic check_rows_0x01(input string tag);
        chk({tag, "_m1_0"}, 256'(ram1[0]), 256'(32'h04030201));
        chk({tag, "_m1_1"}, 256'(ram1[1]), 256'(32'h08070605));
        chk({tag, "_m2_0"}, 256'(ram2[0]), 256'(32'h0C0B0A09));
        chk({tag, "_m2_1"}, 256'(ram2[1]), 256'(32'h100F0E0D));
        chk({tag, "_m2_2"}, 256'(ram2[2]), 256'(32'h14131211));
    endtask

    initial begin
        int base;
        logic [255:0] g;
        rst_n = 1'b0;
        clear = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_data = '0;
        b_if.in_valid = 1'b0; b_if.in_data = '0;
        m_n = 0; m_e1 = 0; m_e2 = 0; m_since = -1; m_addr = 0; m_data = '0;
        for (int i = 0; i < SA; i++) ram1[i] = '0;
        for (int i = 0; i < SC; i++) ram2[i] = '0;
        fork
            monitor();
        join_none
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset in the middle of a row, then a clean continuous load.
        s_send(8'h01, 0);
        s_send(8'h02, 0);
        rst_n = 1'b0;
        s_if.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_ready_after_reset", 256'(s_if.in_ready), 256'(1));
        step();
        base = pulses;
        s_stream(8'h01, TOTAL, 0);
        @(negedge clk);
        chk("t2_done_t1", 256'(s_if.load_done), 256'(0));
        step();
        @(negedge clk);
        chk("t2_done_t2", 256'(s_if.load_done), 256'(1));
        check_rows_0x01("t2");
        chk("t2_pulses", 256'(pulses - base), 256'(5));

        // Inputs offered after completion are ignored.
        base = pulses;
        s_if.in_valid = 1'b1;
        s_if.in_data  = 8'hEE;
        repeat (10) step();
        s_if.in_valid = 1'b0;
        chk("t4_pulses", 256'(pulses - base), 256'(0));
        chk("t4_done_held", 256'(s_if.load_done), 256'(1));

        // Same data with random valid gaps.
        clear = 1'b1;
        step();
        clear = 1'b0;
        for (int i = 0; i < SA; i++) ram1[i] = '0;
        for (int i = 0; i < SC; i++) ram2[i] = '0;
        base = pulses;
        s_stream(8'h01, TOTAL, 50);
        repeat (3) step();
        check_rows_0x01("t3");
        chk("t3_pulses", 256'(pulses - base), 256'(5));

        // Clear with a write pulse in flight, then clear mid M1 row 1.
        clear = 1'b1; step(); clear = 1'b0;
        s_stream(8'h31, 4, 0);
        s_if.in_valid = 1'b1; s_if.in_data = 8'h35; clear = 1'b1;
        step();
        clear = 1'b0;
        s_stream(8'h41, 6, 0);
        s_if.in_valid = 1'b1; s_if.in_data = 8'h47; clear = 1'b1;
        step();
        clear = 1'b0;
        s_stream(8'hA0, TOTAL - 1, 25);
        repeat (3) step();
        chk("t5_not_done_19", 256'(s_if.load_done), 256'(0));
        s_stream(8'hB3, 1, 0);
        repeat (3) step();
        chk("t5_done", 256'(s_if.load_done), 256'(1));
        chk("t5_m1_0", 256'(ram1[0]), 256'(32'hA3A2A1A0));
        chk("t5_m2_2", 256'(ram2[2]), 256'(32'hB3B2B1B0));

        // Default-parameter instance with random data.
        for (int i = 0; i < BIG_N; i++) gold[i] = 8'($urandom);
        for (int i = 0; i < BIG_N; i++) b_send(gold[i], 25);
        b_if.in_valid = 1'b0;
        repeat (3) step();
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < 32; k++) g[k*8 +: 8] = gold[r*32 + k];
            if (r < 16) chk("t6_m1_row", bram1[r], g);
            else        chk("t6_m2_row", bram2[r-16], g);
        end
        chk("t6_done", 256'(b_if.load_done), 256'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
`default_nettype wire
